decode_queue: RTL
=================

// Module: decode_queue
// PURPOSE
//  Buffered RV32I decode stage between fetch and execute, generalising the single-instruction decoder.
//  Raw instructions enter a DEPTH-entry FIFO over a valid/ready handshake.
//  The FIFO head is decoded into a registered output slot with its own valid/ready handshake.
//  Decode provides two source-register ports, a write-enable qualifier and an illegal flag.
//  A flush input discards everything in flight, e.g. on branch redirect.
// PARAMETERS
//  BUS_WIDTH     32  instruction/immediate width; only 32 is supported.
//  OPCODE_WIDTH  11  decoded opcode width = {funct7[5], funct3, opcode[6:0]}; fixed at 11.
//  ADDR_WIDTH     5  register address width.
//  DEPTH          4  FIFO entries; power of 2, >= 2.
// PORTS
//  clk          in   1                   clock; all state updates on posedge.
//  rst          in   1                   asynchronous reset, active-high.
//  instr_valid  in   1                   upstream instruction valid.
//  instr_ready  out  1                   FIFO can accept; transfer when valid&&ready.
//  instr        in   BUS_WIDTH           raw instruction.
//  flush        in   1                   discard FIFO and output slot.
//  dec_valid    out  1                   decoded slot valid.
//  dec_ready    in   1                   downstream accepts the decoded slot.
//  opcode       out  OPCODE_WIDTH        decoded opcode.
//  imme_value   out  BUS_WIDTH           sign-extended immediate.
//  rd_addr      out  ADDR_WIDTH          destination register.
//  rd_we        out  1                   rd is written (0 if rd==0, branch, store or illegal).
//  rs1_addr     out  ADDR_WIDTH          source register 1.
//  rs1_valid    out  1                   rs1 is used.
//  rs2_addr     out  ADDR_WIDTH          source register 2.
//  rs2_valid    out  1                   rs2 is used.
//  illegal      out  1                   opcode not in the RV32I base set.
//  q_count      out  $clog2(DEPTH+1)     FIFO occupancy, excluding the output slot.
// BEHAVIOUR
//  Reset (async, rst=1):
//   - Pointers and q_count clear to 0.
//   - dec_valid and all decoded outputs clear to 0.
//   - instr_ready is 1 once rst deasserts.
//  instr_ready = (q_count != DEPTH); it never depends on dec_ready.
//  Push:
//   - instr_valid && instr_ready writes the FIFO at the tail.
//   - instr is ignored while instr_ready=0.
//  Slot load:
//   - Condition: FIFO non-empty and (dec_valid==0 or dec_ready==1).
//   - Head is popped, decoded and registered; dec_valid becomes 1.
//   - Otherwise a dec_valid && dec_ready handshake clears dec_valid.
//  Simultaneous push and pop: q_count is unchanged; full FIFO plus pop still blocks the push that cycle.
//  Latency and throughput:
//   - Accept at edge N -> dec_valid and decoded fields visible after edge N+1.
//   - Sustained throughput is 1 per cycle.
//  Output stability: while dec_valid && !dec_ready, every decoded output holds stable.
//  Flush (highest priority):
//   - At the edge, pointers and q_count go to 0 and dec_valid goes to 0.
//   - A same-cycle push is dropped and a same-cycle load is suppressed.
//  Pointer wrap: pointers are log2(DEPTH) bits and wrap DEPTH-1 -> 0.
//  opcode field:
//   - opcode[6:0] = instr[6:0].
//   - funct3 = instr[14:12], forced to 0 for LUI/AUIPC/JAL.
//   - funct7[5] = instr[30] only for OP (0110011), and for OP-IMM with funct3 001/101; else 0.
//  Immediates (sign-extended from instr[31]):
//   - I: LOAD, OP-IMM, JALR, SYSTEM.
//   - S: STORE.
//   - B: BRANCH, bit0=0.
//   - U: LUI/AUIPC, low 12 bits = 0.
//   - J: JAL, bit0=0.
//   - Zero for OP, FENCE and illegal.
//  Register usage:
//   - rs1_valid: JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
//   - rs2_valid: BRANCH, STORE, OP.
//   - Address fields always carry the raw instr bits.
//  Illegal:
//   - Cause: instr[1:0] != 2'b11, or opcode not one of LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, FENCE, SYSTEM.
//   - Effect: rd_we, rs1_valid and rs2_valid forced to 0, imme_value = 0.
//   - The entry still flows through with illegal=1.
// TESTING
//  addi x5,x0,-1 (0xFFF00293) -> opcode 0x013, imme 0xFFFFFFFF, rd 5, rd_we 1, rs1_valid 1, rs2_valid 0.
//  sub x3,x1,x2 (0x402081B3) -> opcode 0x433, rs1 1, rs2 2, both valid, rd_we 1, imme 0.
//  beq x1,x2,-4 (0xFE208EE3) -> opcode 0x063, imme 0xFFFFFFFC, rd_we 0; 0x00000000 -> illegal 1, all valids 0.
//  dec_ready=0, push 6 back-to-back:
//   - instr_ready drops after the 5th accept (1 in slot + 4 queued), q_count 4.
//   - Releasing dec_ready drains all 5 in order, one per cycle.
//  flush with q_count 3 and dec_valid 1, plus a same-cycle push -> next cycle q_count 0, dec_valid 0; the pushed instr never appears.
//  rst pulsed mid-stream between edges -> outputs 0 immediately; after release the first new instr appears 2 cycles after accept.

Source files
------------

// File: rtl/decode_queue.sv
// RV32I decode stage: DEPTH-entry instruction FIFO feeding a registered decode slot.
// Both sides use valid/ready; flush empties the FIFO and the slot in one edge.
module decode_queue #(
  parameter int BUS_WIDTH    = 32,
  parameter int OPCODE_WIDTH = 11,
  parameter int ADDR_WIDTH   = 5,
  parameter int DEPTH        = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         instr_valid,
  output logic                         instr_ready,
  input  logic [BUS_WIDTH-1:0]         instr,
  input  logic                         flush,
  output logic                         dec_valid,
  input  logic                         dec_ready,
  output logic [OPCODE_WIDTH-1:0]      opcode,
  output logic [BUS_WIDTH-1:0]         imme_value,
  output logic [ADDR_WIDTH-1:0]        rd_addr,
  output logic                         rd_we,
  output logic [ADDR_WIDTH-1:0]        rs1_addr,
  output logic                         rs1_valid,
  output logic [ADDR_WIDTH-1:0]        rs2_addr,
  output logic                         rs2_valid,
  output logic                         illegal,
  output logic [$clog2(DEPTH+1)-1:0]   q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [BUS_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic                 push;
  logic                 load;
  logic [BUS_WIDTH-1:0] head;

  // instr_ready looks only at occupancy, so a full FIFO blocks a push even when a pop frees a slot
  assign instr_ready = (q_count != FULL_CNT);
  assign push        = instr_valid && instr_ready && !flush;
  assign load        = (q_count != '0) && (!dec_valid || dec_ready) && !flush;
  assign head        = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= instr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (load) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, load})
        2'b10:   q_count <= q_count + 1'b1;
        2'b01:   q_count <= q_count - 1'b1;
        default: q_count <= q_count;
      endcase
    end
  end

  logic [6:0]           d_op7;
  logic [2:0]           d_f3;
  logic                 d_f7;
  logic [BUS_WIDTH-1:0] d_imm;
  logic                 d_writes;
  logic                 d_rd_we;
  logic                 d_rs1_v;
  logic                 d_rs2_v;
  logic                 d_illegal;
  logic [BUS_WIDTH-1:0] imm_i;
  logic [BUS_WIDTH-1:0] imm_s;
  logic [BUS_WIDTH-1:0] imm_b;
  logic [BUS_WIDTH-1:0] imm_u;
  logic [BUS_WIDTH-1:0] imm_j;

  assign imm_i = {{20{head[31]}}, head[31:20]};
  assign imm_s = {{21{head[31]}}, head[30:25], head[11:7]};
  assign imm_b = {{20{head[31]}}, head[7], head[30:25], head[11:8], 1'b0};
  assign imm_u = {head[31:12], 12'b0};
  assign imm_j = {{12{head[31]}}, head[19:12], head[20], head[30:21], 1'b0};

  // Any opcode outside the base set (including low bits != 2'b11) falls to default
  always_comb begin
    d_op7     = head[6:0];
    d_f3      = head[14:12];
    d_f7      = 1'b0;
    d_imm     = '0;
    d_writes  = 1'b1;
    d_rs1_v   = 1'b0;
    d_rs2_v   = 1'b0;
    d_illegal = 1'b0;
    case (d_op7)
      OP_LUI, OP_AUIPC: begin
        d_f3  = 3'b000;
        d_imm = imm_u;
      end
      OP_JAL: begin
        d_f3  = 3'b000;
        d_imm = imm_j;
      end
      OP_JALR: begin
        d_imm   = imm_i;
        d_rs1_v = 1'b1;
      end
      OP_BRANCH: begin
        d_imm    = imm_b;
        d_rs1_v  = 1'b1;
        d_rs2_v  = 1'b1;
        d_writes = 1'b0;
      end
      OP_LOAD: begin
        d_imm   = imm_i;
        d_rs1_v = 1'b1;
      end
      OP_STORE: begin
        d_imm    = imm_s;
        d_rs1_v  = 1'b1;
        d_rs2_v  = 1'b1;
        d_writes = 1'b0;
      end
      OP_IMM: begin
        d_imm   = imm_i;
        d_rs1_v = 1'b1;
        // funct7[5] only distinguishes the shift forms (SRLI/SRAI, SLLI)
        d_f7    = ((head[14:12] == 3'b001) || (head[14:12] == 3'b101)) ? head[30] : 1'b0;
      end
      OP_OP: begin
        d_rs1_v = 1'b1;
        d_rs2_v = 1'b1;
        d_f7    = head[30];
      end
      OP_FENCE: begin
        d_imm = '0;
      end
      OP_SYSTEM: begin
        d_imm = imm_i;
      end
      default: begin
        d_illegal = 1'b1;
        d_writes  = 1'b0;
      end
    endcase
  end

  assign d_rd_we = d_writes && (head[11:7] != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_valid  <= 1'b0;
      opcode     <= '0;
      imme_value <= '0;
      rd_addr    <= '0;
      rd_we      <= 1'b0;
      rs1_addr   <= '0;
      rs1_valid  <= 1'b0;
      rs2_addr   <= '0;
      rs2_valid  <= 1'b0;
      illegal    <= 1'b0;
    end else if (flush) begin
      dec_valid <= 1'b0;
    end else if (load) begin
      dec_valid  <= 1'b1;
      opcode     <= {d_f7, d_f3, d_op7};
      imme_value <= d_imm;
      rd_addr    <= head[11:7];
      rd_we      <= d_rd_we;
      rs1_addr   <= head[19:15];
      rs1_valid  <= d_rs1_v;
      rs2_addr   <= head[24:20];
      rs2_valid  <= d_rs2_v;
      illegal    <= d_illegal;
    end else if (dec_ready) begin
      dec_valid <= 1'b0;
    end
  end

endmodule
